// File: rtl/mmio_timer_slave.sv
// Memory-mapped prescaled 32-bit timer with compare match, overflow flag and level irq.
// Optional PWM output and DUTY register are built when MMIO_TIMER_PWM_EN is defined.
module mmio_timer_slave #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 7,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq,
    output logic                  pwm_o
);

    localparam int unsigned PSC_W      = 8;
    localparam logic [2:0] IDX_CTRL    = 3'd0;
    localparam logic [2:0] IDX_COUNT   = 3'd1;
    localparam logic [2:0] IDX_COMPARE = 3'd2;
    localparam logic [2:0] IDX_STATUS  = 3'd3;
    localparam logic [2:0] IDX_DUTY    = 3'd4;

    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PSC_W-1:0]      r_prescale;
    logic [PSC_W-1:0]      r_psc;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_compare;
    logic                  r_match;
    logic                  r_ovf;
    logic                  r_irq;

    logic [2:0] w_idx;
    logic       w_wr_ctrl;
    logic       w_wr_count;
    logic       w_wr_compare;
    logic       w_wr_status;
    logic       w_tick;
    logic       w_hit;
    logic       w_set_match;
    logic       w_set_ovf;
    logic       w_unused_addr;

    assign w_idx         = address[4:2];
    assign w_unused_addr = ^{address[ADDR_WIDTH-1:5], address[1:0]};
    assign w_wr_ctrl     = we & (w_idx == IDX_CTRL);
    assign w_wr_count    = we & (w_idx == IDX_COUNT);
    assign w_wr_compare  = we & (w_idx == IDX_COMPARE);
    assign w_wr_status   = we & (w_idx == IDX_STATUS);

    // A CPU write to COUNT pre-empts both the increment and the match/overflow evaluation.
    assign w_tick      = r_en & (r_psc == r_prescale);
    assign w_hit       = (r_count == r_compare);
    assign w_set_match = w_tick & ~w_wr_count & w_hit;
    assign w_set_ovf   = w_tick & ~w_wr_count & (&r_count) & ~(r_auto & w_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_psc      <= '0;
            r_count    <= '0;
            r_compare  <= DATA_WIDTH'(RESET_COMPARE);
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en       <= wd[0];
                r_auto     <= wd[1];
                r_irq_en   <= wd[2];
                r_prescale <= wd[15:8];
            end
            // Prescaler is not cleared on PRESCALE writes; an overshoot wraps through 8'hFF.
            if (!r_en || w_tick) begin
                r_psc <= '0;
            end else begin
                r_psc <= r_psc + PSC_W'(1);
            end
            if (w_wr_count) begin
                r_count <= wd;
            end else if (w_tick) begin
                r_count <= (r_auto && w_hit) ? '0 : r_count + DATA_WIDTH'(1);
            end
            if (w_wr_compare) begin
                r_compare <= wd;
            end
            // Hardware set beats a same-cycle write-1-to-clear.
            r_match <= (r_match & ~(w_wr_status & wd[0])) | w_set_match;
            r_ovf   <= (r_ovf   & ~(w_wr_status & wd[1])) | w_set_ovf;
            r_irq   <= r_irq_en & r_match;
        end
    end

    assign irq = r_irq;

`ifdef MMIO_TIMER_PWM_EN
    logic [DATA_WIDTH-1:0] r_duty;
    logic                  r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            if (we && (w_idx == IDX_DUTY)) begin
                r_duty <= wd;
            end
            r_pwm <= r_en & (r_count < r_duty);
        end
    end

    assign pwm_o = r_pwm;
`else
    assign pwm_o = 1'b0;
`endif

    // Zero-latency read mux; shows pre-edge contents even when a write is in flight.
    always_comb begin
        rd = '0;
        if (re) begin
            case (w_idx)
                IDX_CTRL:    rd = DATA_WIDTH'({16'h0, r_prescale, 5'h0, r_irq_en, r_auto, r_en});
                IDX_COUNT:   rd = r_count;
                IDX_COMPARE: rd = r_compare;
                IDX_STATUS:  rd = DATA_WIDTH'({r_ovf, r_match});
`ifdef MMIO_TIMER_PWM_EN
                IDX_DUTY:    rd = r_duty;
`endif
                default:     rd = '0;
            endcase
        end
    end

endmodule
